// File: rtl/chan_word_capture_pkg.sv
// Shared types and helpers for the per-channel word capture block.
package psec5_readout_pkg;

    localparam int unsigned NCH        = 8;
    localparam int unsigned WORD_W_DEF = 50;

    typedef enum logic [1:0] {
        Idle,
        Shift,
        Pend,
        Commit
    } capture_state_t;

    // Known test word: {frame_cnt, chan} zero-extended into the low bits.
    function automatic logic [63:0] pattern_word(input logic [7:0] frame_cnt,
                                                 input logic [2:0] chan);
        return {53'd0, frame_cnt, chan};
    endfunction

endpackage

// File: rtl/chan_word_capture_if.sv
// Capture-side bus: frame request, serial streams, SPI lock and committed outputs.
// Optional test_mode signal exists only when TEST_PATTERN_EN is defined.
interface chan_word_capture_if #(
    parameter int unsigned WORD_W = 50
);
    logic              start;
    logic [7:0]        ser_in;
    logic              rd_lock;
`ifdef TEST_PATTERN_EN
    logic              test_mode;
`endif
    logic [WORD_W-1:0] ch0, ch1, ch2, ch3, ch4, ch5, ch6, ch7;
    logic              busy;
    logic              data_valid;
    logic              overrun;
    logic [7:0]        frame_cnt;

    modport master (
        output start, ser_in, rd_lock,
`ifdef TEST_PATTERN_EN
        output test_mode,
`endif
        input  ch0, ch1, ch2, ch3, ch4, ch5, ch6, ch7,
        input  busy, data_valid, overrun, frame_cnt
    );

    modport slave (
        input  start, ser_in, rd_lock,
`ifdef TEST_PATTERN_EN
        input  test_mode,
`endif
        output ch0, ch1, ch2, ch3, ch4, ch5, ch6, ch7,
        output busy, data_valid, overrun, frame_cnt
    );
endinterface

// File: rtl/chan_shift_capture.sv
// One channel: shadow register filled bit by bit, copied to a stable hold register on commit.
module chan_shift_capture #(
    parameter int unsigned WORD_W = 50,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              iclk,
    input  logic              rstn,
    input  logic              bit_in,
    input  logic [CNT_W-1:0]  bit_idx,
    input  logic              shift_en,
    input  logic              commit_en,
    output logic [WORD_W-1:0] word
);

    logic [WORD_W-1:0] shadow_q, shadow_d;
    logic [WORD_W-1:0] hold_q;

    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < int'(WORD_W); i++) begin
            if (shift_en && (bit_idx == CNT_W'(i))) begin
                shadow_d[i] = bit_in;
            end
        end
    end

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            shadow_q <= '0;
            hold_q   <= '0;
        end else begin
            shadow_q <= shadow_d;
            if (commit_en) begin
                hold_q <= shadow_q;
            end
        end
    end

    assign word = hold_q;

endmodule

// File: rtl/chan_word_capture.sv
// Eight-channel serial word deserialiser with SPI-safe commit of hold outputs.
// Optional build macro TEST_PATTERN_EN replaces ser_in with a known per-channel pattern.
module chan_word_capture
    import psec5_readout_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned CNT_W  = 6
) (
    input logic               iclk,
    input logic               rstn,
    chan_word_capture_if.slave bus
);

    capture_state_t    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              data_valid_q, data_valid_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              test_q, test_d;
    logic              shift_en, commit_en;
    logic [NCH-1:0]    bit_in;
    logic [WORD_W-1:0] word [NCH];

`ifdef TEST_PATTERN_EN
    logic test_sel;
    assign test_sel = bus.test_mode;
`else
    logic test_sel;
    assign test_sel = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;
        frame_cnt_d  = frame_cnt_q;
        test_d       = test_q;
        shift_en     = 1'b0;
        commit_en    = 1'b0;
        // A start outside Idle is dropped but remembered until reset.
        if (bus.start && (state_q != Idle)) begin
            overrun_d = 1'b1;
        end
        unique case (state_q)
            Idle: begin
                if (bus.start) begin
                    state_d      = Shift;
                    cnt_d        = '0;
                    data_valid_d = 1'b0;
                    test_d       = test_sel;
                end
            end
            Shift: begin
                shift_en = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WORD_W - 1)) begin
                    state_d = Pend;
                    cnt_d   = '0;
                end
            end
            Pend: begin
                if (!bus.rd_lock) begin
                    state_d = Commit;
                end
            end
            Commit: begin
                commit_en    = 1'b1;
                frame_cnt_d  = frame_cnt_q + 8'd1;
                data_valid_d = 1'b1;
                state_d      = Idle;
            end
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= Idle;
            cnt_q        <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_cnt_q  <= '0;
            test_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
            frame_cnt_q  <= frame_cnt_d;
            test_q       <= test_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
`ifdef TEST_PATTERN_EN
        logic [63:0] pat;
        assign pat       = pattern_word(frame_cnt_q, 3'(g));
        assign bit_in[g] = test_q ? pat[cnt_q] : bus.ser_in[g];
`else
        assign bit_in[g] = bus.ser_in[g];
`endif
        chan_shift_capture #(
            .WORD_W (WORD_W),
            .CNT_W  (CNT_W)
        ) u_chan (
            .iclk      (iclk),
            .rstn      (rstn),
            .bit_in    (bit_in[g]),
            .bit_idx   (cnt_q),
            .shift_en  (shift_en),
            .commit_en (commit_en),
            .word      (word[g])
        );
    end

    assign bus.ch0        = word[0];
    assign bus.ch1        = word[1];
    assign bus.ch2        = word[2];
    assign bus.ch3        = word[3];
    assign bus.ch4        = word[4];
    assign bus.ch5        = word[5];
    assign bus.ch6        = word[6];
    assign bus.ch7        = word[7];
    assign bus.busy       = (state_q != Idle);
    assign bus.data_valid = data_valid_q;
    assign bus.overrun    = overrun_q;
    assign bus.frame_cnt  = frame_cnt_q;

    // test_q is only consumed by the pattern path.
    logic unused_test;
    assign unused_test = test_q;

endmodule

// File: tb/tb_chan_word_capture.sv
// Randomised bench for chan_word_capture against a frame-level reference model.
module tb_chan_word_capture;

    localparam int unsigned WORD_W = 50;
    localparam int unsigned CNT_W  = 6;

    logic iclk = 1'b0;
    logic rstn = 1'b0;
    always #5 iclk = ~iclk;

    chan_word_capture_if #(.WORD_W(WORD_W)) bus ();

    chan_word_capture #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .iclk (iclk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [WORD_W-1:0] stim    [8];
    logic [WORD_W-1:0] exp_ch  [8];
    int                exp_frame;
    logic              exp_ov;

    function automatic logic [WORD_W-1:0] get_ch(input int c);
        case (c)
            0: return bus.ch0;
            1: return bus.ch1;
            2: return bus.ch2;
            3: return bus.ch3;
            4: return bus.ch4;
            5: return bus.ch5;
            6: return bus.ch6;
            default: return bus.ch7;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[WORD_W-1:0];
    endfunction

    task automatic randomize_stim();
        for (int c = 0; c < 8; c++) stim[c] = rand_word();
    endtask

    task automatic drive_start();
        bus.start = 1'b1;
        @(negedge iclk);
        bus.start = 1'b0;
    endtask

    // Serialise stim LSB first; optionally raise rd_lock or pulse start at a bit index.
    task automatic drive_shift(input int lock_at, input int start_at);
        for (int b = 0; b < int'(WORD_W); b++) begin
            if (b == lock_at) bus.rd_lock = 1'b1;
            bus.start = (b == start_at);
            for (int c = 0; c < 8; c++) bus.ser_in[c] = stim[c][b];
            @(negedge iclk);
        end
        bus.start  = 1'b0;
        bus.ser_in = 8'($urandom());
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 200) begin
            @(negedge iclk);
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: timeout, busy=%b required 0", name, bus.busy);
        end
    endtask

    task automatic model_commit();
        for (int c = 0; c < 8; c++) exp_ch[c] = stim[c];
        exp_frame = (exp_frame + 1) % 256;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(negedge iclk);
        rstn = 1'b1;
        @(negedge iclk);
        for (int c = 0; c < 8; c++) exp_ch[c] = '0;
        exp_frame = 0;
        exp_ov    = 1'b0;
    endtask

    task automatic test_reset();
        bus.start   = 1'b0;
        bus.ser_in  = '0;
        bus.rd_lock = 1'b0;
`ifdef TEST_PATTERN_EN
        bus.test_mode = 1'b0;
`endif
        do_reset();
        checks++;
        if ({bus.busy, bus.data_valid, bus.overrun, bus.frame_cnt} !== 11'd0) begin
            errors++;
            $display("FAIL reset_flags: got busy=%b dv=%b ov=%b fc=%0d required all 0",
                     bus.busy, bus.data_valid, bus.overrun, bus.frame_cnt);
        end
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (get_ch(c) !== '0) begin
                errors++;
                $display("FAIL reset_ch%0d: got %h required 0", c, get_ch(c));
            end
        end
    endtask

    task automatic test_basic();
        for (int c = 0; c < 8; c++) stim[c] = 50'h2_AAAA_5555_1234 + WORD_W'(c);
        drive_start();
        drive_shift(-1, -1);
        // Now in cycle WORD_W+1: waiting to commit, outputs still old.
        checks++;
        if (bus.busy !== 1'b1 || bus.data_valid !== 1'b0 || bus.ch3 !== exp_ch[3]) begin
            errors++;
            $display("FAIL basic_pend: busy=%b dv=%b ch3=%h required 1 0 %h",
                     bus.busy, bus.data_valid, bus.ch3, exp_ch[3]);
        end
        @(negedge iclk);
        checks++;
        if (bus.busy !== 1'b1 || bus.ch0 !== exp_ch[0]) begin
            errors++;
            $display("FAIL basic_commit_cycle: busy=%b ch0=%h required 1 %h",
                     bus.busy, bus.ch0, exp_ch[0]);
        end
        @(negedge iclk);
        model_commit();
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (get_ch(c) !== exp_ch[c]) begin
                errors++;
                $display("FAIL basic_ch%0d: got %h required %h", c, get_ch(c), exp_ch[c]);
            end
        end
        checks++;
        if (bus.data_valid !== 1'b1 || bus.frame_cnt !== 8'(exp_frame) || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_flags: dv=%b fc=%0d busy=%b required 1 %0d 0",
                     bus.data_valid, bus.frame_cnt, bus.busy, exp_frame);
        end
        for (int f = 0; f < 3; f++) begin
            randomize_stim();
            drive_start();
            drive_shift(-1, -1);
            wait_idle("random_idle");
            model_commit();
            for (int c = 0; c < 8; c++) begin
                checks++;
                if (get_ch(c) !== exp_ch[c]) begin
                    errors++;
                    $display("FAIL random_ch%0d: got %h required %h", c, get_ch(c), exp_ch[c]);
                end
            end
        end
    endtask

    task automatic test_rd_lock();
        int bad;
        randomize_stim();
        drive_start();
        drive_shift(9, -1);
        bad = 0;
        // Hold the lock to cycle 100; no commit may happen.
        for (int cyc = int'(WORD_W) + 1; cyc <= 100; cyc++) begin
            if (bus.busy !== 1'b1 || bus.ch6 !== exp_ch[6] || bus.data_valid !== 1'b0) bad++;
            @(negedge iclk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL lock_hold: %0d bad cycles required 0", bad);
        end
        bus.rd_lock = 1'b0;
        @(negedge iclk);
        checks++;
        if (bus.ch6 !== exp_ch[6] || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL lock_release_early: ch6=%h busy=%b required %h 1",
                     bus.ch6, bus.busy, exp_ch[6]);
        end
        @(negedge iclk);
        model_commit();
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (get_ch(c) !== exp_ch[c]) begin
                errors++;
                $display("FAIL lock_ch%0d: got %h required %h", c, get_ch(c), exp_ch[c]);
            end
        end
    endtask

    task automatic test_overrun();
        randomize_stim();
        drive_start();
        drive_shift(-1, 19);
        exp_ov = 1'b1;
        wait_idle("overrun_idle");
        model_commit();
        checks++;
        if (bus.overrun !== exp_ov || bus.frame_cnt !== 8'(exp_frame)) begin
            errors++;
            $display("FAIL overrun_flags: ov=%b fc=%0d required %b %0d",
                     bus.overrun, bus.frame_cnt, exp_ov, exp_frame);
        end
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (get_ch(c) !== exp_ch[c]) begin
                errors++;
                $display("FAIL overrun_ch%0d: got %h required %h", c, get_ch(c), exp_ch[c]);
            end
        end
    endtask

    task automatic test_mid_reset();
        randomize_stim();
        drive_start();
        for (int b = 0; b < 25; b++) begin
            for (int c = 0; c < 8; c++) bus.ser_in[c] = stim[c][b];
            @(negedge iclk);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.data_valid, bus.overrun, bus.frame_cnt} !== 11'd0 ||
            bus.ch2 !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: busy=%b dv=%b ov=%b fc=%0d ch2=%h required 0",
                     bus.busy, bus.data_valid, bus.overrun, bus.frame_cnt, bus.ch2);
        end
        @(negedge iclk);
        rstn = 1'b1;
        for (int c = 0; c < 8; c++) exp_ch[c] = '0;
        exp_frame = 0;
        exp_ov    = 1'b0;
        @(negedge iclk);
        randomize_stim();
        drive_start();
        drive_shift(-1, -1);
        wait_idle("midreset_idle");
        model_commit();
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (get_ch(c) !== exp_ch[c]) begin
                errors++;
                $display("FAIL midreset_ch%0d: got %h required %h", c, get_ch(c), exp_ch[c]);
            end
        end
        checks++;
        if (bus.frame_cnt !== 8'd1 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL midreset_count: fc=%0d ov=%b required 1 0",
                     bus.frame_cnt, bus.overrun);
        end
    endtask

    task automatic test_back_to_back();
        int dv_bad;
        dv_bad = 0;
        while (exp_frame != 0) begin
            randomize_stim();
            drive_start();
            if (bus.data_valid !== 1'b0) dv_bad++;
            drive_shift(-1, -1);
            wait_idle("b2b_idle");
            model_commit();
            if (bus.data_valid !== 1'b1) dv_bad++;
        end
        checks++;
        if (dv_bad != 0) begin
            errors++;
            $display("FAIL b2b_data_valid: %0d bad samples required 0", dv_bad);
        end
        checks++;
        if (bus.frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL b2b_wrap: fc=%0d required 0", bus.frame_cnt);
        end
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (get_ch(c) !== exp_ch[c]) begin
                errors++;
                $display("FAIL b2b_ch%0d: got %h required %h", c, get_ch(c), exp_ch[c]);
            end
        end
    endtask

`ifdef TEST_PATTERN_EN
    task automatic test_pattern();
        do_reset();
        for (int f = 0; f < 3; f++) begin
            randomize_stim();
            drive_start();
            drive_shift(-1, -1);
            wait_idle("pattern_pre_idle");
            model_commit();
        end
        for (int c = 0; c < 8; c++) stim[c] = WORD_W'((exp_frame << 3) | c);
        randomize_stim_keep();
        bus.test_mode = 1'b1;
        drive_start();
        bus.test_mode = 1'b0;
        drive_shift_random();
        wait_idle("pattern_idle");
        checks++;
        if (bus.ch5 !== 50'h1D || bus.ch0 !== 50'h18) begin
            errors++;
            $display("FAIL pattern_fixed: ch5=%h ch0=%h required 1d 18", bus.ch5, bus.ch0);
        end
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (get_ch(c) !== WORD_W'((3 << 3) | c)) begin
                errors++;
                $display("FAIL pattern_ch%0d: got %h required %h", c, get_ch(c),
                         WORD_W'((3 << 3) | c));
            end
        end
    endtask

    task automatic randomize_stim_keep();
    endtask

    // Serial lines carry noise; the pattern must win.
    task automatic drive_shift_random();
        for (int b = 0; b < int'(WORD_W); b++) begin
            bus.ser_in = 8'($urandom());
            @(negedge iclk);
        end
    endtask
`endif

    initial begin
        exp_frame = 0;
        exp_ov    = 1'b0;
        @(negedge iclk);
        test_reset();
        test_basic();
        test_rd_lock();
        test_overrun();
        test_mid_reset();
        test_back_to_back();
`ifdef TEST_PATTERN_EN
        test_pattern();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
